// File: rtl/davranis_pkg.sv
// Shared definitions for the behaviour filter link: widths, decoder FSM states, codeword builder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package davranis_pkg;

  localparam int KOD_W = 5;
  localparam int SAF_W = 3;

  typedef enum logic [1:0] {BOS, TOPLA, COZ} durum_t;

  function automatic logic [KOD_W-1:0] kodla(input logic [SAF_W-1:0] saf);
    return {saf, saf[2] ^ saf[1], saf[1] ^ saf[0]};
  endfunction

endpackage

// File: rtl/davranis_cozucu_sayac_doygun.sv
// Saturating event counter: increments on artir, sticks at all-ones.
// Latency: count visible one cycle after artir.
// Backpressure: none, artir is sampled every cycle.
module sayac_doygun #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         artir,
  output logic [W-1:0] deger
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deger <= '0;
    end else if (artir && (deger != {W{1'b1}})) begin
      deger <= deger + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/davranis_cozucu.sv
// Serial codeword receiver: collects 5 bits MSB-first, checks parity, emits saf or an error pulse.
// Latency: result registered one cycle after the 5th bit is accepted; abort error on the restart bit.
// Backpressure: hazir drops for the single decode cycle only.
module davranis_cozucu
  import davranis_pkg::*;
#(
  parameter int SAYAC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               baslat,
  input  logic               seri_gecerli,
  input  logic               seri_veri,
  output logic               hazir,
  output logic [SAF_W-1:0]   saf_cikis,
  output logic               cikis_gecerli,
  output logic               hata,
  output logic [SAYAC_W-1:0] gecerli_sayac,
  output logic [SAYAC_W-1:0] hata_sayac
);

  durum_t           durum, durum_d;
  logic [KOD_W-1:0] kayit, kayit_d;
  logic [2:0]       sayi, sayi_d;
  logic [SAF_W-1:0] saf_d;
  logic             gecerli_d, hata_d;
  logic             kabul;

  assign hazir = (durum != COZ);
  assign kabul = seri_gecerli && hazir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum         <= BOS;
      kayit         <= '0;
      sayi          <= '0;
      saf_cikis     <= '0;
      cikis_gecerli <= 1'b0;
      hata          <= 1'b0;
    end else begin
      durum         <= durum_d;
      kayit         <= kayit_d;
      sayi          <= sayi_d;
      saf_cikis     <= saf_d;
      cikis_gecerli <= gecerli_d;
      hata          <= hata_d;
    end
  end

  always_comb begin
    durum_d   = durum;
    kayit_d   = kayit;
    sayi_d    = sayi;
    saf_d     = saf_cikis;
    gecerli_d = 1'b0;
    hata_d    = 1'b0;
    case (durum)
      BOS: begin
        if (kabul && baslat) begin
          kayit_d = {{(KOD_W-1){1'b0}}, seri_veri};
          sayi_d  = 3'd1;
          durum_d = TOPLA;
        end
      end
      TOPLA: begin
        if (kabul) begin
          if (baslat) begin
            // a new start mid-frame drops the partial word and restarts on this bit
            kayit_d = {{(KOD_W-1){1'b0}}, seri_veri};
            sayi_d  = 3'd1;
            hata_d  = 1'b1;
          end else begin
            kayit_d = {kayit[KOD_W-2:0], seri_veri};
            sayi_d  = sayi + 3'd1;
            if (sayi == 3'(KOD_W-1)) begin
              durum_d = COZ;
            end
          end
        end
      end
      COZ: begin
        if (kayit == kodla(kayit[KOD_W-1:KOD_W-SAF_W])) begin
          saf_d     = kayit[KOD_W-1:KOD_W-SAF_W];
          gecerli_d = 1'b1;
        end else begin
          hata_d = 1'b1;
        end
        sayi_d  = '0;
        durum_d = BOS;
      end
      default: durum_d = BOS;
    endcase
  end

  sayac_doygun #(.W(SAYAC_W)) u_gecerli_sayac (
    .clk   (clk),
    .rst_n (rst_n),
    .artir (gecerli_d),
    .deger (gecerli_sayac)
  );

  sayac_doygun #(.W(SAYAC_W)) u_hata_sayac (
    .clk   (clk),
    .rst_n (rst_n),
    .artir (hata_d),
    .deger (hata_sayac)
  );

endmodule

// File: tb/tb_davranis_cozucu.sv
// Directed bench for davranis_cozucu: expected pulses queued at stimulus time, checked as the DUT emits them.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_davranis_cozucu;
  import davranis_pkg::*;

  typedef struct {
    logic             hata;
    logic [SAF_W-1:0] saf;
    int               cyc;
  } bek_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baslat = 1'b0;
  logic seri_gecerli = 1'b0;
  logic seri_veri = 1'b0;

  logic             hazir, cikis_gecerli, hata;
  logic [SAF_W-1:0] saf_cikis;
  logic [7:0]       gecerli_sayac, hata_sayac;

  logic             hazir2, cikis_gecerli2, hata2;
  logic [SAF_W-1:0] saf_cikis2;
  logic [1:0]       gecerli_sayac2, hata_sayac2;

  bek_t             q[$];
  int               tests = 0;
  int               fails = 0;
  int               ncyc = 0;
  int               exp_gec = 0;
  int               exp_hat = 0;
  logic [SAF_W-1:0] son_iyi = '0;

  davranis_cozucu #(.SAYAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .baslat(baslat), .seri_gecerli(seri_gecerli),
    .seri_veri(seri_veri), .hazir(hazir), .saf_cikis(saf_cikis),
    .cikis_gecerli(cikis_gecerli), .hata(hata),
    .gecerli_sayac(gecerli_sayac), .hata_sayac(hata_sayac)
  );

  davranis_cozucu #(.SAYAC_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baslat(baslat), .seri_gecerli(seri_gecerli),
    .seri_veri(seri_veri), .hazir(hazir2), .saf_cikis(saf_cikis2),
    .cikis_gecerli(cikis_gecerli2), .hata(hata2),
    .gecerli_sayac(gecerli_sayac2), .hata_sayac(hata_sayac2)
  );

  always #5 clk = ~clk;

  function automatic int doy(input int x, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic kontrol(input string tag, input logic [31:0] obs, input logic [31:0] bek);
    tests++;
    assert (obs === bek) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, bek);
    end
  endtask

  task automatic sayac_kontrol();
    kontrol("gecerli_sayac", 32'(gecerli_sayac), 32'(doy(exp_gec, 8)));
    kontrol("hata_sayac", 32'(hata_sayac), 32'(doy(exp_hat, 8)));
    kontrol("gecerli_sayac_w2", 32'(gecerli_sayac2), 32'(doy(exp_gec, 2)));
    kontrol("hata_sayac_w2", 32'(hata_sayac2), 32'(doy(exp_hat, 2)));
  endtask

  task automatic izle();
    bek_t e;
    if (q.size() > 0 && q[0].cyc < ncyc) begin
      tests++;
      fails++;
      $error("FAIL eksik_darbe: observed no pulse expected pulse at cycle %0d", q[0].cyc);
      void'(q.pop_front());
    end
    if (cikis_gecerli || hata) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL beklenmeyen_darbe: observed gecerli=%0b hata=%0b expected none", cikis_gecerli, hata);
      end else begin
        e = q.pop_front();
        kontrol("darbe_zamani", 32'(ncyc), 32'(e.cyc));
        kontrol("hata_darbe", 32'(hata), 32'(e.hata));
        kontrol("gecerli_darbe", 32'(cikis_gecerli), 32'(!e.hata));
        kontrol("ayni_anda", 32'(cikis_gecerli && hata), 32'(0));
        kontrol("saf_cikis", 32'(saf_cikis), 32'(e.saf));
        kontrol("hata_darbe_w2", 32'(hata2), 32'(e.hata));
        kontrol("gecerli_darbe_w2", 32'(cikis_gecerli2), 32'(!e.hata));
      end
    end
  endtask

  task automatic bit_gonder(input logic b, input logic bas, input bit bosluk);
    if (bosluk) begin
      repeat ($urandom_range(0, 2)) begin
        seri_gecerli = 1'b0;
        @(posedge clk); #1;
      end
    end
    seri_gecerli = 1'b1;
    seri_veri    = b;
    baslat       = bas;
    @(posedge clk); #1;
    seri_gecerli = 1'b0;
    seri_veri    = 1'b0;
    baslat       = 1'b0;
  endtask

  // nbit < 5 sends only the leading bits; kes marks the first bit as aborting a partial frame
  task automatic kelime_gonder(input logic [KOD_W-1:0] w, input int nbit, input bit bosluk, input bit kes);
    bek_t e;
    logic iyi;
    for (int i = KOD_W - 1; i >= KOD_W - nbit; i--) begin
      bit_gonder(w[i], i == KOD_W - 1, bosluk);
      if (i == KOD_W - 1 && kes) begin
        exp_hat++;
        e.hata = 1'b1; e.saf = son_iyi; e.cyc = ncyc;
        q.push_back(e);
      end
    end
    if (nbit == KOD_W) begin
      iyi = (w == kodla(w[4:2]));
      if (iyi) begin
        son_iyi = w[4:2];
        exp_gec++;
      end else begin
        exp_hat++;
      end
      e.hata = !iyi; e.saf = son_iyi; e.cyc = ncyc + 1;
      q.push_back(e);
      kontrol("hazir_coz", 32'(hazir), 32'(0));
      kontrol("hazir_coz_w2", 32'(hazir2), 32'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_kontrol(input string tag);
    kontrol({tag, "_saf"}, 32'(saf_cikis), 32'(0));
    kontrol({tag, "_gecerli"}, 32'(cikis_gecerli), 32'(0));
    kontrol({tag, "_hata"}, 32'(hata), 32'(0));
    kontrol({tag, "_hazir"}, 32'(hazir), 32'(1));
    sayac_kontrol();
  endtask

  initial begin
    fork
      forever begin @(posedge clk); ncyc++; end
      forever begin @(negedge clk); izle(); end
    join_none

    repeat (2) @(posedge clk);
    #1;
    reset_kontrol("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // stray bits without a start are ignored while idle
    bit_gonder(1'b1, 1'b0, 1'b0);
    bit_gonder(1'b1, 1'b0, 1'b0);
    kontrol("bos_hazir", 32'(hazir), 32'(1));

    kelime_gonder(5'h1C, 5, 1'b0, 1'b0);
    sayac_kontrol();

    for (int s = 7; s >= 0; s--) begin
      kelime_gonder(kodla(3'(s)), 5, 1'b0, 1'b0);
    end
    sayac_kontrol();

    kelime_gonder(kodla(3'd5), 5, 1'b0, 1'b0);
    kelime_gonder(5'h1D, 5, 1'b0, 1'b0);
    kontrol("saf_hatada_sabit", 32'(saf_cikis), 32'(5));
    sayac_kontrol();

    kelime_gonder(5'h17, 3, 1'b0, 1'b0);
    kelime_gonder(5'h0B, 5, 1'b0, 1'b1);
    kontrol("kesme_sonrasi_saf", 32'(saf_cikis), 32'(2));
    sayac_kontrol();

    kelime_gonder(5'h17, 3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    son_iyi = '0; exp_gec = 0; exp_hat = 0;
    reset_kontrol("ara_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    kelime_gonder(5'h05, 5, 1'b1, 1'b0);
    kontrol("reset_sonrasi_saf", 32'(saf_cikis), 32'(1));
    sayac_kontrol();

    for (int n = 0; n < 5; n++) begin
      kelime_gonder(5'h1D, 5, 1'b0, 1'b0);
      sayac_kontrol();
    end
    kontrol("doygun_w2", 32'(hata_sayac2), 32'(3));

    repeat (3) @(posedge clk);
    #1;
    kontrol("kuyruk_bos", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
